// File: rtl/perf_monitor.sv
// perf_monitor: run-time event and cycle counters for the CPU pipeline.
// Live counters, shadow snapshot, indexed readout and a cycle-limit halt.
module perf_monitor #(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0,
    parameter int SEL_W    = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic               clr_i,
    input  logic               snap_i,
    input  logic               rd_en_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_valid_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               running_o,
    output logic               halt_o
);

    localparam int NC = NUM_EVT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt     [NC];
    logic [CNT_W-1:0] cnt_nxt [NC];
    logic [CNT_W-1:0] shadow  [NC];
    logic [NC-1:0]    inc;
    logic [NC-1:0]    wrap;
    logic [NC-1:0]    ovf_q;
    logic [CNT_W-1:0] rd_mux;
    logic             run;
    logic             lim_hit;

    assign run   = (state == RUN);
    assign ovf_o = ovf_q;

    // Per-counter increment, overflow detect and next value.
    always_comb begin
        inc              = '0;
        inc[NUM_EVT-1:0] = run ? evt_i : '0;
        inc[NUM_EVT]     = run;
        wrap             = '0;
        for (int i = 0; i < NC; i++) begin
            cnt_nxt[i] = cnt[i];
            wrap[i]    = inc[i] && (&cnt[i]);
            if (inc[i] && !(wrap[i] && SATURATE)) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Limit reached when the cycle counter lands on a nonzero limit.
    always_comb begin
        lim_hit = run && (limit_i != '0) &&
                  (cnt_nxt[NUM_EVT] == limit_i);
    end

    // State register; clear and reset both force IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a limit hit beats a pause on the same edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = RUN;
            RUN: begin
                if (lim_hit)       state_nxt = DONE;
                else if (!start_i) state_nxt = IDLE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state flops.
    always_comb begin
        running_o = (state == RUN);
        halt_o    = (state == DONE);
    end

    // Live counters, shadows and sticky overflow flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) begin
            for (int i = 0; i < NC; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (snap_i) shadow[i] <= cnt[i];
            end
            ovf_q <= ovf_q | wrap;
        end
    end

    // Shadow select; out-of-range indexes read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NC; i++) begin
            if (rd_sel_i == SEL_W'(i)) rd_mux = shadow[i];
        end
    end

    // Readout port; clear does not touch it so a pending read completes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_mux;
        end
    end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable event-counting monitor for the pipelined CPU. It replaces ad-hoc stall, flush and cycle counting in simulation with a parametrised hardware block that can also be read at run time. It counts NUM_EVT event lines plus a free cycle counter while the CPU runs, and stops counting at a programmable cycle limit. It supports atomic snapshot, clear and indexed readout, and sits beside CPU, fed by hazard-detection and control strobes.

## Interface
Parameters:
- NUM_EVT, 4: number of event counters (1..16).
- CNT_W, 32: width of every counter, including the cycle counter.
- SATURATE, 0: 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0.
- SEL_W, $clog2(NUM_EVT+1): width of the readout index.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- start_i  in  1  run enable; 1 = count, 0 = pause.
- evt_i  in  NUM_EVT  event strobes; bit i = one event for counter i this cycle.
- limit_i  in  CNT_W  cycle limit; 0 = unlimited. Sampled every cycle.
- clr_i  in  1  synchronous clear of counters, shadows, overflow flags and state.
- snap_i  in  1  copy all live counters into shadow registers.
- rd_en_i  in  1  readout request.
- rd_sel_i  in  SEL_W  readout index; 0..NUM_EVT-1 = event counter, NUM_EVT = cycle counter.
- rd_data_o  out  CNT_W  shadow value of the selected counter.
- rd_valid_o  out  1  rd_data_o valid, one-cycle pulse.
- ovf_o  out  NUM_EVT+1  sticky overflow flags; bit NUM_EVT = cycle counter.
- running_o  out  1  state == RUN.
- halt_o  out  1  state == DONE (cycle limit reached).

## Operation
- FSM states: IDLE, RUN, DONE. Outputs are registered.
- IDLE -> RUN when start_i=1.
- RUN -> IDLE when start_i=0. This is a pause: counters hold.
- RUN -> DONE on the edge where the cycle counter becomes equal to limit_i, with limit_i≠0.
- DONE stays in DONE until clr_i or reset. start_i is ignored in DONE.
- Counting happens only on edges taken in state RUN:
  - cycle counter += 1.
  - counter i += 1 when evt_i[i]=1.
  - Events in the final RUN cycle, the one that reaches the limit, are counted.
- Overflow:
  - When a counter at all-ones is incremented, it becomes 0 if SATURATE=0 and stays all-ones if SATURATE=1.
  - The matching ovf_o bit sets in either mode and stays set until clr_i or reset.
  - With SATURATE=0, a wrapped cycle counter keeps comparing against limit_i.
- Snapshot: snap_i=1 loads every shadow with the live counter value from before the edge. Increments made on the same edge are not captured.
- Readout:
  - rd_en_i=1 gives rd_valid_o=1 on the next cycle, with rd_data_o = shadow[rd_sel_i] as it was before that edge.
  - If snap_i and rd_en_i are high together, rd_data_o returns the old shadow.
  - An out-of-range rd_sel_i returns 0 with rd_valid_o=1.
  - rd_data_o holds its value when rd_valid_o=0.
- clr_i:
  - Zeroes live counters, shadows and ovf_o, and forces IDLE.
  - It wins over counting, snap_i and limit detection on the same edge.
  - A read pending on that edge still returns the pre-clear shadow.
- Reset (rst_i=0 at an edge), including mid-run: same effect as clr_i. In addition, rd_data_o=0 and rd_valid_o=0.

## Timing
- Reset values: rd_data_o=0, rd_valid_o=0, ovf_o=0, running_o=0, halt_o=0, state IDLE, all counters and shadows 0.
- start_i high at edge k: counting begins at edge k+1 and running_o=1 after edge k.
- An event at the input reaches the live counter on the same edge. It is visible through snapshot plus read 2 cycles later at the earliest: snap at edge n+1, read data after edge n+2.
- With limit L starting from 0 and start_i held high from edge 0: RUN after edge 0, cycle counter = L after edge L, and halt_o=1 after edge L.
- Read latency is fixed at 1 cycle. Back-to-back reads are allowed every cycle.

## Test plan
- Reset then start_i=1, limit_i=30, evt_i[0] high on 7 separate cycles → after edge 30: halt_o=1, running_o=0. After snap then read sel=4: 30. Read sel=0: 7.
- start_i high for 5 cycles, low for 3, high for 5, limit 0 → cycle counter = 10 and halt_o=0. Events asserted during the pause are not counted.
- CNT_W=4, SATURATE=0, evt_i[1] held for 17 RUN cycles → counter 1 = 1 and ovf_o[1]=1. Repeat with SATURATE=1 → 15 and ovf_o[1]=1.
- Snapshot with counter 2 = 5 and evt_i[2]=1 on the same edge, then read sel=2 → 5. A second snap then read → 6.
- clr_i asserted together with snap_i and evt_i after 12 run cycles → all reads return 0, ovf_o=0, state IDLE.
- rst_i=0 mid-run at cycle 8, held 1 cycle → all outputs 0 on the next cycle. The run restarts from 0 when start_i=1.
